// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// wb_bus_arbiter : round-robin sharing of one classic Wishbone slave bus
//                  between N masters, with an ACK watchdog.
// Revision       : 1.0
// ============================================================================
module wb_bus_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                                i_CLK,
    input  logic                                i_RST,
    input  logic [N_MASTERS-1:0]                i_M_CYC,
    input  logic [N_MASTERS-1:0]                i_M_STB,
    input  logic [N_MASTERS-1:0]                i_M_WE,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]     i_M_ADDR,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]     i_M_DATA,
    input  logic [N_MASTERS*DATA_WIDTH/8-1:0]   i_M_SEL,
    output logic [N_MASTERS-1:0]                o_M_ACK,
    output logic [N_MASTERS-1:0]                o_M_ERR,
    output logic [DATA_WIDTH-1:0]               o_M_DATA,
    output logic                                o_S_CYC,
    output logic                                o_S_STB,
    output logic                                o_S_WE,
    output logic [ADDR_WIDTH-1:0]               o_S_ADDR,
    output logic [DATA_WIDTH-1:0]               o_S_DATA,
    output logic [DATA_WIDTH/8-1:0]             o_S_SEL,
    input  logic                                i_S_ACK,
    input  logic [DATA_WIDTH-1:0]               i_S_DATA,
    output logic [N_MASTERS-1:0]                o_GNT
);

    localparam int c_SEL_W = DATA_WIDTH / 8;
    localparam int c_PTR_W = $clog2(N_MASTERS);
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam logic [N_MASTERS-1:0] c_ONE = {{(N_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [c_PTR_W-1:0]     ptr_q, ptr_d;
    logic [c_TMR_W-1:0]     tmr_q, tmr_d;

    logic                   w_busy;
    logic                   w_own_cyc;
    logic                   w_own_stb;
    logic                   w_timeout;
    logic                   w_ack;
    logic [c_PTR_W-1:0]     w_winner;

    // Lowest rotation distance from the last winner wins; the last winner
    // itself is checked last, so it only wins again when nobody else asks.
    function automatic logic [c_PTR_W-1:0] f_pick(
        input logic [N_MASTERS-1:0] req,
        input logic [c_PTR_W-1:0]   last
    );
        logic [c_PTR_W-1:0] pick;
        logic [c_PTR_W-1:0] idx;
        pick = last;
        for (int i = N_MASTERS; i >= 1; i--) begin
            idx = c_PTR_W'((int'(last) + i) % N_MASTERS);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign w_winner  = f_pick(i_M_CYC, ptr_q);
    assign w_busy    = (state_q == ST_BUSY);
    assign w_own_cyc = w_busy & i_M_CYC[ptr_q];
    assign w_own_stb = w_own_cyc & i_M_STB[ptr_q];
    // ACK has priority over the watchdog in the same cycle.
    assign w_timeout = w_own_stb & ~i_S_ACK & (tmr_q == c_TMR_LAST);

    assign o_S_CYC  = w_own_cyc & ~w_timeout;
    assign o_S_STB  = w_own_stb & ~w_timeout;
    assign o_S_WE   = w_busy & i_M_WE[ptr_q];
    assign w_ack    = i_S_ACK & o_S_STB;
    assign o_M_ACK  = gnt_q & {N_MASTERS{w_ack}};
    assign o_M_ERR  = gnt_q & {N_MASTERS{w_timeout}};
    assign o_M_DATA = i_S_DATA;
    assign o_GNT    = gnt_q;

    always_comb begin
        o_S_ADDR = '0;
        o_S_DATA = '0;
        o_S_SEL  = '0;
        if (w_busy) begin
            o_S_ADDR = i_M_ADDR[int'(ptr_q)*ADDR_WIDTH +: ADDR_WIDTH];
            o_S_DATA = i_M_DATA[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH];
            o_S_SEL  = i_M_SEL[int'(ptr_q)*c_SEL_W +: c_SEL_W];
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        tmr_d   = '0;
        if (w_own_stb && !i_S_ACK && !w_timeout) begin
            tmr_d = tmr_q + c_TMR_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (|i_M_CYC) begin
                    state_d = ST_BUSY;
                    ptr_d   = w_winner;
                    gnt_d   = c_ONE << w_winner;
                end
            end
            ST_BUSY: begin
                // Owner release always costs one idle cycle before re-arbitration.
                if (!i_M_CYC[ptr_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= c_PTR_W'(N_MASTERS - 1);
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            tmr_q   <= tmr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// Directed-vector bench for wb_bus_arbiter (2 masters, TIMEOUT = 4).
module tb_wb_bus_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0A00;
    localparam logic [31:0] A1 = 32'h0000_1000;
    localparam logic [31:0] Z  = 32'h0000_0000;
    localparam logic [31:0] D0 = 32'h0A0A_0A0A;
    localparam logic [31:0] D1 = 32'h1B1B_1B1B;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [63:0] m_addr, m_data;
    logic [7:0]  m_sel;
    logic [1:0]  m_ack, m_err, gnt;
    logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [3:0]  s_sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(
        .N_MASTERS (2),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_M_CYC (m_cyc),
        .i_M_STB (m_stb),
        .i_M_WE  (m_we),
        .i_M_ADDR(m_addr),
        .i_M_DATA(m_data),
        .i_M_SEL (m_sel),
        .o_M_ACK (m_ack),
        .o_M_ERR (m_err),
        .o_M_DATA(m_rdata),
        .o_S_CYC (s_cyc),
        .o_S_STB (s_stb),
        .o_S_WE  (s_we),
        .o_S_ADDR(s_addr),
        .o_S_DATA(s_wdata),
        .o_S_SEL (s_sel),
        .i_S_ACK (s_ack),
        .i_S_DATA(s_rdata),
        .o_GNT   (gnt)
    );

    typedef struct packed {
        logic        rst;
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic [1:0]  gnt;
        logic        scyc;
        logic        sstb;
        logic [1:0]  mack;
        logic [1:0]  merr;
        logic        we;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[36];

    function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [1:0] s,
                                input logic a, input logic [1:0] g, input logic sc,
                                input logic ss, input logic [1:0] ma, input logic [1:0] me,
                                input logic w, input logic [31:0] ad);
        vec_t v;
        v = '{rst: r, cyc: c, stb: s, ack: a, gnt: g, scyc: sc, sstb: ss,
              mack: ma, merr: me, we: w, addr: ad};
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] c, input logic [1:0] s,
                        input logic a);
        @(negedge clk);
        rst   = r;
        m_cyc = c;
        m_stb = s;
        s_ack = a;
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] eg;
        int         waited;

        // Each row: inputs held for one cycle, outputs expected during that cycle.
        //            rst cyc    stb    ack  gnt    scyc sstb mack   merr   we   addr
        vecs[0]  = mk(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );
        vecs[1]  = mk(0, 2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );
        vecs[2]  = mk(0, 2'b10, 2'b10, 0, 2'b10, 1, 1, 2'b00, 2'b00, 1, A1);
        vecs[3]  = mk(0, 2'b10, 2'b10, 0, 2'b10, 1, 1, 2'b00, 2'b00, 1, A1);
        vecs[4]  = mk(0, 2'b10, 2'b10, 1, 2'b10, 1, 1, 2'b10, 2'b00, 1, A1);
        vecs[5]  = mk(0, 2'b00, 2'b00, 0, 2'b10, 0, 0, 2'b00, 2'b00, 1, A1);
        vecs[6]  = mk(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );
        // both request from reset: M0, dead cycle, M1 (M0 re-request waits), M0
        vecs[7]  = mk(1, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );
        vecs[8]  = mk(0, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );
        vecs[9]  = mk(0, 2'b11, 2'b11, 1, 2'b01, 1, 1, 2'b01, 2'b00, 0, A0);
        vecs[10] = mk(0, 2'b10, 2'b10, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0, A0);
        vecs[11] = mk(0, 2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );
        vecs[12] = mk(0, 2'b11, 2'b11, 0, 2'b10, 1, 1, 2'b00, 2'b00, 1, A1);
        vecs[13] = mk(0, 2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 2'b00, 1, A1);
        vecs[14] = mk(0, 2'b01, 2'b01, 0, 2'b10, 0, 0, 2'b00, 2'b00, 1, A1);
        vecs[15] = mk(0, 2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );
        vecs[16] = mk(0, 2'b01, 2'b01, 1, 2'b01, 1, 1, 2'b01, 2'b00, 0, A0);
        vecs[17] = mk(0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0, A0);
        vecs[18] = mk(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );
        // watchdog: ERR on 4th STB cycle, then ACK exactly on the timeout cycle
        vecs[19] = mk(0, 2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );
        vecs[20] = mk(0, 2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0, A0);
        vecs[21] = mk(0, 2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0, A0);
        vecs[22] = mk(0, 2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0, A0);
        vecs[23] = mk(0, 2'b01, 2'b01, 0, 2'b01, 0, 0, 2'b00, 2'b01, 0, A0);
        vecs[24] = mk(0, 2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0, A0);
        vecs[25] = mk(0, 2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0, A0);
        vecs[26] = mk(0, 2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0, A0);
        vecs[27] = mk(0, 2'b01, 2'b01, 1, 2'b01, 1, 1, 2'b01, 2'b00, 0, A0);
        vecs[28] = mk(0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0, A0);
        vecs[29] = mk(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );
        // reset while M0 busy: pointer returns to N-1 so M0 beats M1 again
        vecs[30] = mk(0, 2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );
        vecs[31] = mk(1, 2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0, A0);
        vecs[32] = mk(0, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );
        vecs[33] = mk(0, 2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0, A0);
        // owner drops CYC with STB and slave ACK present: aborted, no ACK
        vecs[34] = mk(0, 2'b00, 2'b01, 1, 2'b01, 0, 0, 2'b00, 2'b00, 0, A0);
        vecs[35] = mk(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, Z );

        rst     = 1'b1;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = 2'b10;
        m_addr  = {A1, A0};
        m_data  = {D1, D0};
        m_sel   = {4'b1111, 4'b0011};
        s_ack   = 1'b0;
        s_rdata = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < $size(vecs); i++) begin
            step(vecs[i].rst, vecs[i].cyc, vecs[i].stb, vecs[i].ack);
            check("vec", i,
                  64'({gnt, s_cyc, s_stb, m_ack, m_err, s_we, s_addr}),
                  64'({vecs[i].gnt, vecs[i].scyc, vecs[i].sstb, vecs[i].mack,
                       vecs[i].merr, vecs[i].we, vecs[i].addr}));
        end

        // Continuous requests from both masters: grants must alternate 01,10,...
        step(1, 2'b11, 2'b11, 0);
        for (int t = 0; t < 8; t++) begin
            eg = (t % 2 == 0) ? 2'b01 : 2'b10;
            step(0, 2'b11, 2'b11, 0);
            waited = 0;
            while (gnt == 2'b00 && waited < 4) begin
                step(0, 2'b11, 2'b11, 0);
                waited++;
            end
            check("rr_gnt", t, 64'(gnt), 64'(eg));
            check("rr_wdata", t, 64'({s_wdata, s_sel}),
                  (eg == 2'b01) ? 64'({D0, 4'b0011}) : 64'({D1, 4'b1111}));
            s_rdata = 32'hD000_0000 | 32'(t);
            s_ack   = 1'b1;
            #1;
            check("rr_ack", t, 64'(m_ack), 64'(eg));
            check("rr_rdata", t, 64'(m_rdata), 64'(32'hD000_0000 | 32'(t)));
            step(0, ~eg, ~eg, 0);
        end
        step(0, 2'b00, 2'b00, 0);
        step(0, 2'b00, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
